// File: rtl/data_mem_responder_if.sv
// Load/store request and response channels between the core (master) and data memory (slave).
interface data_mem_responder_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_funct3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Latency-programmable byte-addressed RV64 data memory responder, one transaction in flight.
// Optional define MISALIGN_TRAP_EN: misaligned h/w/d accesses return resp_err instead of executing.
module data_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 256,
    parameter int unsigned LATENCY     = 2
) (
    input logic                  clk,
    input logic                  reset,
    data_mem_responder_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH_BYTES);
    localparam int unsigned CW = 4;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic           lat_write;
    logic [2:0]     lat_funct3;
    logic [63:0]    lat_addr;
    logic [63:0]    lat_wdata;
    logic [7:0]     mem [DEPTH_BYTES];

    logic           req_ready_q, req_ready_d;
    logic           resp_valid_q, resp_valid_d;
    logic [63:0]    resp_rdata_q;
    logic           resp_err_q;

    logic           accept_c, complete_c;
    logic [3:0]     size_c;
    logic [64:0]    last_c;
    logic           range_err_c, enc_err_c, align_err_c, err_c;
    logic [AW-1:0]  base_c;
    logic [63:0]    load_c;
    logic           sign_c;

    assign accept_c   = (state_q == IDLE) && bus.req_valid;
    assign complete_c = (state_q == WAIT) && (cnt_q == '0);

    // Decode the latched request: size, error checks and the extended load value.
    always_comb begin
        size_c      = 4'd1 << lat_funct3[1:0];
        last_c      = {1'b0, lat_addr} + 65'(size_c) - 65'd1;
        range_err_c = last_c >= 65'(DEPTH_BYTES);
        enc_err_c   = (lat_funct3 == 3'b111) || (lat_write && lat_funct3[2]);
`ifdef MISALIGN_TRAP_EN
        align_err_c = (lat_addr[3:0] & (size_c - 4'd1)) != 4'd0;
`else
        align_err_c = 1'b0;
`endif
        err_c  = range_err_c || enc_err_c || align_err_c;
        base_c = lat_addr[AW-1:0];
        sign_c = 1'b0;
        load_c = '0;
        for (int i = 0; i < 8; i++) begin
            if (4'(i) < size_c) begin
                load_c[8*i +: 8] = mem[base_c + AW'(i)];
                sign_c           = load_c[8*i+7];
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (4'(i) >= size_c) begin
                load_c[8*i +: 8] = {8{sign_c & ~lat_funct3[2]}};
            end
        end
    end

    // State register plus registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.req_valid) state_d = WAIT;
            WAIT:    if (cnt_q == '0)   state_d = RESP;
            RESP:    if (bus.resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the flops present it the cycle the state is entered.
    always_comb begin
        req_ready_d  = 1'b0;
        resp_valid_d = 1'b0;
        if (state_d == IDLE) req_ready_d  = 1'b1;
        if (state_d == RESP) resp_valid_d = 1'b1;
    end

    // Request latch, latency counter and response data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            lat_write    <= 1'b0;
            lat_funct3   <= '0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            if (accept_c) begin
                lat_write  <= bus.req_write;
                lat_funct3 <= bus.req_funct3;
                lat_addr   <= bus.req_addr;
                lat_wdata  <= bus.req_wdata;
                cnt_q      <= CW'(LATENCY - 1);
            end else if ((state_q == WAIT) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - CW'(1);
            end
            if (complete_c) begin
                resp_err_q   <= err_c;
                resp_rdata_q <= (err_c || lat_write) ? 64'd0 : load_c;
            end
        end
    end

    // Storage; stores commit only at completion and only when error-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
                mem[AW'(i)] <= '0;
            end
        end else if (complete_c && lat_write && !err_c) begin
            for (int i = 0; i < 8; i++) begin
                if (4'(i) < size_c) begin
                    mem[base_c + AW'(i)] <= lat_wdata[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Table-driven scoreboard bench for data_mem_responder plus backpressure and mid-transaction reset sequences.
module tb_data_mem_responder;
    localparam int unsigned DEPTH = 256;
    localparam int unsigned LAT   = 2;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .LATENCY(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   accept_cyc = 0;
    logic prev_valid = 1'b0;
    vec_t exp_q[$];
    vec_t vt[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    function automatic vec_t mk(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                                input logic [63:0] wdata, input logic [63:0] er, input logic ee);
        vec_t v;
        v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = er; v.exp_err = ee;
        return v;
    endfunction

    always @(posedge clk) cyc++;

    // Scoreboard: record acceptance, compare on the rising edge of resp_valid.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.req_valid && bus.req_ready) accept_cyc = cyc + 1;
            if (bus.resp_valid && !prev_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_resp", 64'd1, 64'd0);
                end else begin
                    vec_t e;
                    e = exp_q.pop_front();
                    check($sformatf("rdata@%h", e.addr), bus.resp_rdata, e.exp_rdata);
                    check($sformatf("err@%h", e.addr), 64'(bus.resp_err), 64'(e.exp_err));
                    check($sformatf("latency@%h", e.addr), 64'(cyc - accept_cyc), 64'(LAT));
                end
            end
        end
        prev_valid = bus.resp_valid;
    end

    task automatic drive_req(input vec_t v);
        bus.req_valid  = 1'b1;
        bus.req_write  = v.wr;
        bus.req_funct3 = v.f3;
        bus.req_addr   = v.addr;
        bus.req_wdata  = v.wdata;
    endtask

    task automatic wait_accept();
        int t = 0;
        @(negedge clk);
        while (!bus.req_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_resp();
        int t = 0;
        @(negedge clk);
        while (!bus.resp_valid && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check("resp_timeout", 64'd1, 64'd0);
    endtask

    task automatic run_txn(input vec_t v);
        @(posedge clk); #1;
        drive_req(v);
        exp_q.push_back(v);
        wait_accept();
        wait_resp();
        @(negedge clk);
        check("resp_valid_drop", 64'(bus.resp_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_funct3 = '0;
        bus.req_addr = '0; bus.req_wdata = '0; bus.resp_ready = 1'b1;
        reset = 1'b0;

        vt.push_back(mk(1, 3'b011, 64'h10, 64'h1122334455667788, 64'h0, 0));
        vt.push_back(mk(0, 3'b011, 64'h10, 64'h0, 64'h1122334455667788, 0));
        vt.push_back(mk(1, 3'b000, 64'h20, 64'h5555555555555580, 64'h0, 0));
        vt.push_back(mk(0, 3'b000, 64'h20, 64'h0, 64'hFFFFFFFFFFFFFF80, 0));
        vt.push_back(mk(0, 3'b100, 64'h20, 64'h0, 64'h80, 0));
        vt.push_back(mk(0, 3'b001, 64'h20, 64'h0, 64'h80, 0));
        vt.push_back(mk(0, 3'b011, 64'hFC, 64'h0, 64'h0, 1));
        vt.push_back(mk(1, 3'b010, 64'h100, 64'h12345678, 64'h0, 1));
        vt.push_back(mk(0, 3'b010, 64'hFC, 64'h0, 64'h0, 0));
        vt.push_back(mk(0, 3'b111, 64'h0, 64'h0, 64'h0, 1));
        vt.push_back(mk(1, 3'b110, 64'h30, 64'hAABBCCDD, 64'h0, 1));
        vt.push_back(mk(0, 3'b010, 64'h30, 64'h0, 64'h0, 0));
        vt.push_back(mk(1, 3'b001, 64'h12, 64'hFFFF8001, 64'h0, 0));
        vt.push_back(mk(0, 3'b011, 64'h10, 64'h0, 64'h1122334480017788, 0));
        vt.push_back(mk(0, 3'b010, 64'h10, 64'h0, 64'hFFFFFFFF80017788, 0));
        vt.push_back(mk(0, 3'b110, 64'h10, 64'h0, 64'h0000000080017788, 0));
        vt.push_back(mk(0, 3'b101, 64'h12, 64'h0, 64'h8001, 0));
        vt.push_back(mk(0, 3'b001, 64'h12, 64'h0, 64'hFFFFFFFFFFFF8001, 0));
        vt.push_back(mk(1, 3'b011, 64'hF8, 64'hCAFEBABE01020304, 64'h0, 0));
        vt.push_back(mk(0, 3'b011, 64'hF8, 64'h0, 64'hCAFEBABE01020304, 0));
        vt.push_back(mk(0, 3'b010, 64'hFC, 64'h0, 64'hFFFFFFFFCAFEBABE, 0));
        vt.push_back(mk(0, 3'b011, 64'hFFFFFFFFFFFFFFF8, 64'h0, 64'h0, 1));
        vt.push_back(mk(0, 3'b011, 64'hFFFFFFFFFFFFFFFC, 64'h0, 64'h0, 1));
        vt.push_back(mk(1, 3'b010, 64'h41, 64'h00000000DEADBEEF, 64'h0, TRAP));
        vt.push_back(mk(0, 3'b110, TRAP ? 64'h40 : 64'h41, 64'h0, TRAP ? 64'h0 : 64'hDEADBEEF, 0));
        vt.push_back(mk(0, 3'b001, 64'h21, 64'h0, 64'h0, TRAP));

        // Reset values while held in reset
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vt[i]) run_txn(vt[i]);

        // Backpressure: response held for 5 cycles while a competing request is offered
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        v = mk(0, 3'b011, 64'h10, 64'h0, 64'h1122334480017788, 0);
        drive_req(v);
        exp_q.push_back(v);
        wait_accept();
        wait_resp();
        @(posedge clk); #1;
        drive_req(mk(0, 3'b000, 64'h20, 64'h0, 64'h0, 0));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
            check("bp_rdata", bus.resp_rdata, 64'h1122334480017788);
            check("bp_req_ready", 64'(bus.req_ready), 64'd0);
        end
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_valid", 64'(bus.resp_valid), 64'd0);
        check("bp_release_ready", 64'(bus.req_ready), 64'd1);
        repeat (4) @(negedge clk);
        check("bp_no_stray_accept", 64'(bus.req_ready), 64'd1);

        // Reset between acceptance and completion discards the store and clears memory
        @(posedge clk); #1;
        drive_req(mk(1, 3'b011, 64'h08, 64'hFFFFFFFFFFFFFFFF, 64'h0, 0));
        wait_accept();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_idle_valid", 64'(bus.resp_valid), 64'd0);
        run_txn(mk(0, 3'b011, 64'h08, 64'h0, 64'h0, 0));
        run_txn(mk(0, 3'b011, 64'h10, 64'h0, 64'h0, 0));

        repeat (3) @(negedge clk);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
